// File: rtl/sky130_ef_ip__sar_adc.sv
// ---------------------------------------------------------------------------
// sky130_ef_ip__sar_adc
// Behavioral model of a successive-approximation ADC. A conversion samples
// vin once, then resolves one bit per clock, MSB first, against vref.
//
// Parameters
//   FUNCTIONAL : 1 = behavioral model, 0 = empty shell (outputs tied low)
//   NBITS      : converter resolution, legal range 4..16
//
// Ports
//   vdd, vss, dvdd, dvss : power pins (only with USE_POWER_PINS)
//   clk    : conversion clock, rising edge
//   resetb : asynchronous active-low reset
//   vin    : analog input (real)
//   vref   : full-scale reference (real)
//   ena    : enable; low during a conversion aborts it
//   start  : conversion request, sampled on the clock edge while idle
//   busy   : high while a conversion is in progress
//   done   : one-cycle pulse in the cycle dout is updated
//   dout   : last completed conversion code
//   ovr    : over/under-range flag of the last conversion
//            (only with SAR_ADC_OVERRANGE_EN)
//
// Configuration macros
//   SAR_ADC_OVERRANGE_EN : adds the ovr output and its register
//   USE_POWER_PINS       : adds the power pins
// ---------------------------------------------------------------------------
module sky130_ef_ip__sar_adc #(
  parameter int FUNCTIONAL = 1,
  parameter int NBITS      = 10
) (
`ifdef USE_POWER_PINS
  input  logic             vdd,
  input  logic             vss,
  input  logic             dvdd,
  input  logic             dvss,
`endif
  input  logic             clk,
  input  logic             resetb,
  input  real              vin,
  input  real              vref,
  input  logic             ena,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [NBITS-1:0] dout
`ifdef SAR_ADC_OVERRANGE_EN
  ,
  output logic             ovr
`endif
);

  localparam int IW = (NBITS > 1) ? $clog2(NBITS) : 1;

  typedef enum logic {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } stateT;

  generate
    if (FUNCTIONAL != 0) begin : g_model

      localparam real             FULLSCALE = 2.0 ** NBITS;
      localparam logic [NBITS-1:0] ONE      = {{(NBITS-1){1'b0}}, 1'b1};
      localparam logic [IW-1:0]    MSB_IDX  = IW'(NBITS - 1);

      stateT            r_state;
      logic [NBITS-1:0] r_code;
      logic [IW-1:0]    r_idx;
      real              r_sample;
      logic [NBITS-1:0] r_dout;
      logic             r_done;

      stateT            w_stateNxt;
      logic [NBITS-1:0] w_codeNxt;
      logic [IW-1:0]    w_idxNxt;
      real              w_sampleNxt;
      logic [NBITS-1:0] w_doutNxt;
      logic             w_doneNxt;
      logic [NBITS-1:0] w_bit;
      logic [NBITS-1:0] w_trial;
      real              w_threshold;
      logic             w_keep;
      logic             w_outOfRange;

`ifdef SAR_ADC_OVERRANGE_EN
      logic             r_ovr;
      logic             w_ovrNxt;
`endif

      // State and datapath registers; reset clears everything at once.
      always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
          r_state  <= IDLE;
          r_code   <= '0;
          r_idx    <= '0;
          r_sample <= 0.0;
          r_dout   <= '0;
          r_done   <= 1'b0;
`ifdef SAR_ADC_OVERRANGE_EN
          r_ovr    <= 1'b0;
`endif
        end else begin
          r_state  <= w_stateNxt;
          r_code   <= w_codeNxt;
          r_idx    <= w_idxNxt;
          r_sample <= w_sampleNxt;
          r_dout   <= w_doutNxt;
          r_done   <= w_doneNxt;
`ifdef SAR_ADC_OVERRANGE_EN
          r_ovr    <= w_ovrNxt;
`endif
        end
      end

      // Next-state logic. A non-positive vref never keeps a bit, which pins
      // the code at zero; negative samples and samples at or above vref fall
      // out of the ordinary bit decisions as 0 and all-ones respectively.
      always_comb begin
        w_stateNxt   = r_state;
        w_codeNxt    = r_code;
        w_idxNxt     = r_idx;
        w_sampleNxt  = r_sample;
        w_doutNxt    = r_dout;
        w_doneNxt    = 1'b0;
`ifdef SAR_ADC_OVERRANGE_EN
        w_ovrNxt     = r_ovr;
`endif
        w_bit        = ONE << r_idx;
        w_trial      = r_code | w_bit;
        w_threshold  = real'(w_trial) * vref / FULLSCALE;
        w_keep       = (vref > 0.0) && (r_sample >= w_threshold);
        w_outOfRange = (r_sample < 0.0) || (r_sample >= vref);

        case (r_state)
          IDLE: begin
            if (ena && start) begin
              w_sampleNxt = vin;
              w_codeNxt   = '0;
              w_idxNxt    = MSB_IDX;
              w_stateNxt  = CONVERT;
            end
          end
          CONVERT: begin
            if (!ena) begin
              w_stateNxt = IDLE;
            end else begin
              w_codeNxt = w_keep ? w_trial : (r_code & ~w_bit);
              if (r_idx == '0) begin
                w_doutNxt  = w_codeNxt;
                w_doneNxt  = 1'b1;
                w_stateNxt = IDLE;
`ifdef SAR_ADC_OVERRANGE_EN
                w_ovrNxt   = w_outOfRange;
`endif
              end else begin
                w_idxNxt = r_idx - 1'b1;
              end
            end
          end
          default: w_stateNxt = IDLE;
        endcase
      end

      assign busy = (r_state == CONVERT);
      assign done = r_done;
      assign dout = r_dout;
`ifdef SAR_ADC_OVERRANGE_EN
      assign ovr  = r_ovr;
`endif

    end else begin : g_shell
      assign busy = 1'b0;
      assign done = 1'b0;
      assign dout = '0;
`ifdef SAR_ADC_OVERRANGE_EN
      assign ovr  = 1'b0;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_sky130_ef_ip__sar_adc.sv
// ---------------------------------------------------------------------------
// tb_sky130_ef_ip__sar_adc
// Self-checking bench for the SAR ADC model at NBITS=10. Expected codes come
// from an ideal transfer function: floor(sample * 2^N / vref), clamped.
// ---------------------------------------------------------------------------
module tb_sky130_ef_ip__sar_adc;

  localparam int  N     = 10;
  localparam real VREF0 = 3.3;

  logic         clk    = 1'b0;
  logic         resetb = 1'b1;
  logic         ena    = 1'b0;
  logic         start  = 1'b0;
  real          vin    = 0.0;
  real          vref   = VREF0;
  logic         busy;
  logic         done;
  logic [N-1:0] dout;
`ifdef SAR_ADC_OVERRANGE_EN
  logic         ovr;
`endif

  int errors = 0;
  int checks = 0;

  sky130_ef_ip__sar_adc #(
    .FUNCTIONAL (1),
    .NBITS      (N)
  ) dut (
`ifdef USE_POWER_PINS
    .vdd    (1'b1),
    .vss    (1'b0),
    .dvdd   (1'b1),
    .dvss   (1'b0),
`endif
    .clk    (clk),
    .resetb (resetb),
    .vin    (vin),
    .vref   (vref),
    .ena    (ena),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .dout   (dout)
`ifdef SAR_ADC_OVERRANGE_EN
    ,
    .ovr    (ovr)
`endif
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Ideal converter transfer function.
  function automatic int expCode(input real s, input real vr);
    real x;
    if (vr <= 0.0) return 0;
    if (s < 0.0) return 0;
    x = s * (2.0 ** N) / vr;
    if (x >= real'((1 << N) - 1)) return (1 << N) - 1;
    return int'($floor(x));
  endfunction

  function automatic bit expOvr(input real s, input real vr);
    return (s < 0.0) || (s >= vr);
  endfunction

  // Requests a conversion and returns once the start edge has passed.
  task automatic applyStimulus(input real v);
    @(negedge clk);
    vin   = v;
    ena   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after the start edge until done, bounded.
  task automatic waitDone(output int lat, output bit seen);
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // Reset must clear outputs without any clock edge.
  task automatic test_reset();
    resetb = 1'b1;
    #1;
    resetb = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || dout !== '0) begin
      errors++;
      $display("[TB] FAIL resetState: busy=%b done=%b dout=%0d required 0/0/0", busy, done, dout);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || dout !== '0) begin
      errors++;
      $display("[TB] FAIL resetHeld: busy=%b dout=%0d required 0/0", busy, dout);
    end
    @(negedge clk);
    resetb = 1'b1;
  endtask

  // Nominal conversion, latency, pulse width and sample hold.
  task automatic test_basic();
    int lat;
    bit seen;
    applyStimulus(1.0);
    vin = 3.0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basicBusy: busy=%b required 1", busy);
    end
    waitDone(lat, seen);
    checks++;
    if (!seen || lat != N) begin
      errors++;
      $display("[TB] FAIL basicLatency: seen=%0d lat=%0d required 1/%0d", seen, lat, N);
    end
    checks++;
    if (dout !== N'(expCode(1.0, VREF0))) begin
      errors++;
      $display("[TB] FAIL basicDout: dout=%0d required %0d", dout, expCode(1.0, VREF0));
    end
`ifdef SAR_ADC_OVERRANGE_EN
    checks++;
    if (ovr !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basicOvr: ovr=%b required 0", ovr);
    end
`endif
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || dout !== N'(expCode(1.0, VREF0))) begin
      errors++;
      $display("[TB] FAIL basicAfter: done=%b busy=%b dout=%0d required 0/0/%0d", done, busy, dout, expCode(1.0, VREF0));
    end
  endtask

  // Out-of-range samples and non-positive references.
  task automatic test_outOfRange();
    real vins[4];
    real vrefs[4];
    int  lat;
    bit  seen;
    vins  = '{3.5, -0.1, 1.0, 1.0};
    vrefs = '{3.3, 3.3, 0.0, -1.0};
    for (int i = 0; i < 4; i++) begin
      vref = vrefs[i];
      applyStimulus(vins[i]);
      waitDone(lat, seen);
      checks++;
      if (!seen || dout !== N'(expCode(vins[i], vrefs[i]))) begin
        errors++;
        $display("[TB] FAIL rangeDout%0d: seen=%0d dout=%0d required %0d", i, seen, dout, expCode(vins[i], vrefs[i]));
      end
`ifdef SAR_ADC_OVERRANGE_EN
      checks++;
      if (ovr !== expOvr(vins[i], vrefs[i])) begin
        errors++;
        $display("[TB] FAIL rangeOvr%0d: ovr=%b required %b", i, ovr, expOvr(vins[i], vrefs[i]));
      end
`endif
    end
    vref = VREF0;
  endtask

  // start held high: conversions every N+1 cycles, none accepted while busy.
  task automatic test_back_to_back();
    int pulses[$];
    int lat;
    bit seen;
    @(negedge clk);
    vin   = 2.0;
    ena   = 1'b1;
    start = 1'b1;
    for (int e = 1; e <= 45; e++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        pulses.push_back(e);
        checks++;
        if (dout !== N'(expCode(2.0, VREF0)) || busy !== 1'b0) begin
          errors++;
          $display("[TB] FAIL b2bPulse@%0d: dout=%0d busy=%b required %0d/0", e, dout, busy, expCode(2.0, VREF0));
        end
      end
    end
    start = 1'b0;
    checks++;
    if (pulses.size() != 4) begin
      errors++;
      $display("[TB] FAIL b2bCount: pulses=%0d required 4", pulses.size());
    end
    for (int k = 1; k < pulses.size(); k++) begin
      checks++;
      if (pulses[k] - pulses[k-1] != N + 1) begin
        errors++;
        $display("[TB] FAIL b2bInterval%0d: interval=%0d required %0d", k, pulses[k] - pulses[k-1], N + 1);
      end
    end
    waitDone(lat, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL b2bDrain: seen=%0d required 1", seen);
    end
  endtask

  // Dropping ena mid-conversion aborts without done and keeps dout.
  task automatic test_abort();
    int lat;
    bit seen;
    bit sawDone;
    applyStimulus(1.0);
    waitDone(lat, seen);
    checks++;
    if (!seen || dout !== N'(expCode(1.0, VREF0))) begin
      errors++;
      $display("[TB] FAIL abortPrep: seen=%0d dout=%0d required %0d", seen, dout, expCode(1.0, VREF0));
    end
    applyStimulus(2.5);
    repeat (4) @(posedge clk);
    #1;
    ena = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abortBusy: busy=%b required 0", busy);
    end
    sawDone = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) sawDone = 1'b1;
    end
    checks++;
    if (sawDone || dout !== N'(expCode(1.0, VREF0))) begin
      errors++;
      $display("[TB] FAIL abortNoDone: sawDone=%0d dout=%0d required 0/%0d", sawDone, dout, expCode(1.0, VREF0));
    end
    ena = 1'b1;
  endtask

  // Reset between edges mid-conversion clears immediately; restart works.
  task automatic test_async_reset();
    int lat;
    bit seen;
    applyStimulus(1.5);
    repeat (3) @(posedge clk);
    #3;
    resetb = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || dout !== '0) begin
      errors++;
      $display("[TB] FAIL asyncReset: busy=%b done=%b dout=%0d required 0/0/0", busy, done, dout);
    end
    @(negedge clk);
    resetb = 1'b1;
    vin    = 1.0;
    ena    = 1'b1;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL resetRestartBusy: busy=%b required 1", busy);
    end
    waitDone(lat, seen);
    checks++;
    if (!seen || lat != N || dout !== N'(expCode(1.0, VREF0))) begin
      errors++;
      $display("[TB] FAIL resetRestart: seen=%0d lat=%0d dout=%0d required 1/%0d/%0d", seen, lat, dout, N, expCode(1.0, VREF0));
    end
  endtask

  // start with ena low never begins a conversion.
  task automatic test_ena_low();
    bit bad;
    @(negedge clk);
    ena   = 1'b0;
    start = 1'b1;
    vin   = 1.0;
    bad   = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (busy !== 1'b0 || done !== 1'b0) bad = 1'b1;
    end
    start = 1'b0;
    ena   = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("[TB] FAIL enaLow: activity seen with ena=0, required none");
    end
  endtask

  // Random codes and references; vin is disturbed after the start edge.
  task automatic test_random();
    int  c;
    int  lat;
    bit  seen;
    real v;
    for (int i = 0; i < 12; i++) begin
      vref = (i % 3 == 0) ? VREF0 : real'($urandom_range(1000, 5000)) / 1000.0;
      c    = int'($urandom_range(0, (1 << N) - 1));
      v    = (real'(c) + 0.5) * vref / (2.0 ** N);
      applyStimulus(v);
      vin = real'($urandom_range(0, 4000)) / 1000.0;
      waitDone(lat, seen);
      checks++;
      if (!seen || lat != N || dout !== N'(expCode(v, vref))) begin
        errors++;
        $display("[TB] FAIL random%0d: seen=%0d lat=%0d dout=%0d required 1/%0d/%0d", i, seen, lat, dout, N, expCode(v, vref));
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    vref = VREF0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_outOfRange();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_ena_low();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so a stuck run still terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
